// File: rtl/serial_add_sub.sv
// -----------------------------------------------------------------------------
// serial_add_sub
//   Digit-serial two's-complement adder/subtractor. Operands are processed
//   DIGIT bits per clock, LSB first, through a DIGIT-bit ripple of full adders
//   linked across cycles by a single carry flop. Subtraction inverts B at
//   capture time and seeds the carry with 1.
//
// Handshake (valid/ready semantics, single point of reference):
//   start is a request that is accepted on a rising clk edge only while the
//   FSM is in IDLE or DONE (busy == 0). An accepted start captures A, B and
//   Binv; the operation then runs for N = WIDTH/DIGIT cycles with busy high,
//   and done pulses for exactly one cycle when Sum and the flags become valid.
//   start while busy is ignored. Holding start high in DONE begins the next
//   operation directly, with no IDLE cycle in between.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   start             operation request
//   A, B [WIDTH]      operands, captured on accepted start
//   Binv              0: A+B, 1: A-B, captured on accepted start
//   busy              high while digits are being processed
//   done              one-cycle result-valid pulse
//   Sum [WIDTH]       result, held until the next operation completes
//   Cout              carry out of the MSB (sub: 1 = no borrow)
//   Ovf               signed overflow
//   Zero, Neg         Sum == 0, Sum[WIDTH-1]
//   dbg_state [2]     current FSM state (0 IDLE, 1 RUN, 2 DONE)
// -----------------------------------------------------------------------------
module serial_add_sub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Binv,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic             Zero,
  output logic             Neg,
  output logic [1:0]       dbg_state
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Ripple datapath for the current digit
  logic [DIGIT-1:0] dig_sum;
  logic             cy;
  logic             cin_top;    // carry into the top bit of this digit
  logic [WIDTH-1:0] res_shift;  // result register after this digit enters

  always_comb begin
    cy      = carry_q;
    cin_top = carry_q;
    dig_sum = '0;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) cin_top = cy;
      dig_sum[i] = a_q[i] ^ b_q[i] ^ cy;
      cy         = (a_q[i] & b_q[i]) | (cy & (a_q[i] ^ b_q[i]));
    end
    // New digit enters from the MSB side; after N digits the LSB digit has
    // reached bit 0. Written as shifts so DIGIT == WIDTH needs no special case.
    res_shift = (res_q >> DIGIT) | (WIDTH'(dig_sum) << (WIDTH - DIGIT));
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    neg_d   = neg_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d     = A;
          b_d     = B ^ {WIDTH{Binv}};
          carry_d = Binv;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        res_d   = res_shift;
        carry_d = cy;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d = S_DONE;
          sum_d   = res_shift;
          cout_d  = cy;
          ovf_d   = cin_top ^ cy;
          zero_d  = (res_shift == '0);
          neg_d   = res_shift[WIDTH-1];
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign Sum       = sum_q;
  assign Cout      = cout_q;
  assign Ovf       = ovf_q;
  assign Zero      = zero_q;
  assign Neg       = neg_q;
  assign dbg_state = state_q;

endmodule
